// File: rtl/bsg_edge_tep_pkg.sv
// ============================================================================
//  Module   : bsg_edge_tep_pkg
//  Brief    : Shared types for the edge traffic endpoint (state, packet, link).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Packet layout LSB first: x, then y, then sequence number in the remaining bits.
`define BSG_EDGE_TEP_PACKET_S(w, xw, yw) \
    struct packed { \
        logic [(w)-(xw)-(yw)-1:0] seq; \
        logic [(yw)-1:0]          y_cord; \
        logic [(xw)-1:0]          x_cord; \
    }

// Ready_and link slice in the same bit order as the bsg_noc_links sif macros.
`define BSG_EDGE_TEP_LINK_S(w) \
    struct packed { \
        logic           v; \
        logic [(w)-1:0] data; \
        logic           ready_and_rev; \
    }

package bsg_edge_tep_pkg;

    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eSEND = 2'd1,
        eWAIT = 2'd2,
        eDONE = 2'd3
    } tep_state_e;

    function automatic int seq_width(input int width, input int x_w, input int y_w);
        return width - x_w - y_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_edge_tep_checker.sv
// ============================================================================
//  Module   : bsg_edge_tep_checker
//  Brief    : RX side: consumes beats, counts them, sticky address/seq error.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_edge_tep_checker
    import bsg_edge_tep_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int x_cord_width_p = 5,
    parameter int y_cord_width_p = 5,
    parameter int num_pkts_p     = 16,
    localparam int cnt_w         = $clog2(num_pkts_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      clear_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    output logic [cnt_w-1:0]          recv_count_o,
    output logic                      error_o
);

    localparam int c_seq_w = seq_width(width_p, x_cord_width_p, y_cord_width_p);

    typedef `BSG_EDGE_TEP_PACKET_S(width_p, x_cord_width_p, y_cord_width_p) packet_s;

    packet_s          w_pkt;
    logic [cnt_w-1:0] r_count;
    logic             r_error;
    logic [cnt_w-1:0] w_count_base;
    logic             w_error_base;
    logic             w_mismatch;
    logic             w_saturated;

    assign w_pkt = packet_s'(data_i);

    // A start clears the run; a beat in the same cycle is judged as the first of the new run.
    assign w_count_base = clear_i ? '0   : r_count;
    assign w_error_base = clear_i ? 1'b0 : r_error;

    assign w_mismatch  = (w_pkt.x_cord != my_x_i) || (w_pkt.y_cord != my_y_i)
                      || (w_pkt.seq != c_seq_w'(w_count_base));
    assign w_saturated = (w_count_base == cnt_w'(num_pkts_p));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_count <= (v_i && !w_saturated) ? w_count_base + cnt_w'(1) : w_count_base;
            r_error <= w_error_base | (v_i & (w_saturated | w_mismatch));
        end
    end

    assign recv_count_o = r_count;
    assign error_o      = r_error;

endmodule

`default_nettype wire

// File: rtl/bsg_router_edge_traffic_endpoint.sv
// ============================================================================
//  Module   : bsg_router_edge_traffic_endpoint
//  Brief    : Edge-link traffic source/sink; optional TX throttle under the
//             BSG_EDGE_TEP_THROTTLE_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_router_edge_traffic_endpoint
    import bsg_edge_tep_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int x_cord_width_p    = 5,
    parameter int y_cord_width_p    = 5,
    parameter int num_pkts_p        = 16,
    parameter int max_outstanding_p = 4,
    localparam int cnt_w            = $clog2(num_pkts_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [x_cord_width_p-1:0] dest_x_i,
    input  logic [y_cord_width_p-1:0] dest_y_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic [width_p+1:0]        link_i,
    output logic [width_p+1:0]        link_o,
    output logic [cnt_w-1:0]          sent_count_o,
    output logic [cnt_w-1:0]          recv_count_o,
    output logic                      error_o,
    output logic                      done_o
);

    localparam int c_seq_w = seq_width(width_p, x_cord_width_p, y_cord_width_p);

    typedef `BSG_EDGE_TEP_PACKET_S(width_p, x_cord_width_p, y_cord_width_p) packet_s;
    typedef `BSG_EDGE_TEP_LINK_S(width_p) link_s;

    if ((c_seq_w < 31 && num_pkts_p > (1 << c_seq_w)) || max_outstanding_p < 1) begin : g_param_check
        $error("bsg_router_edge_traffic_endpoint: num_pkts_p exceeds seq range or bad max_outstanding_p");
    end

    tep_state_e                r_state;
    tep_state_e                w_state_next;
    link_s                     w_link_in;
    link_s                     w_link_out;
    packet_s                   w_pkt_out;
    logic [x_cord_width_p-1:0] r_dest_x;
    logic [y_cord_width_p-1:0] r_dest_y;
    logic [cnt_w-1:0]          r_sent;
    logic [cnt_w-1:0]          w_recv;
    logic                      r_ready;
    logic                      w_v;
    logic                      w_hs;
    logic                      w_start_ok;
    logic                      w_throttle;

    assign w_link_in  = link_s'(link_i);
    assign w_start_ok = start_i && (r_state == eIDLE || r_state == eDONE);
    assign w_hs       = w_v & w_link_in.ready_and_rev;

`ifdef BSG_EDGE_TEP_THROTTLE_EN
    logic [cnt_w-1:0] w_outstanding;
    assign w_outstanding = (r_sent >= w_recv) ? r_sent - w_recv : '0;
    assign w_throttle    = (32'(w_outstanding) >= 32'(max_outstanding_p));
`else
    assign w_throttle    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= eIDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            eIDLE, eDONE: if (start_i) w_state_next = eSEND;
            eSEND:        if (w_hs && r_sent == cnt_w'(num_pkts_p - 1)) w_state_next = eWAIT;
            eWAIT:        if (w_recv == cnt_w'(num_pkts_p)) w_state_next = eDONE;
            default:      w_state_next = eIDLE;
        endcase
    end

    // v depends only on registered state and counters, never on incoming ready.
    always_comb begin
        w_v    = (r_state == eSEND) && !w_throttle;
        done_o = (r_state == eDONE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_sent   <= '0;
            r_dest_x <= '0;
            r_dest_y <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_start_ok) begin
                r_sent   <= '0;
                r_dest_x <= dest_x_i;
                r_dest_y <= dest_y_i;
            end else if (w_hs) begin
                r_sent <= r_sent + cnt_w'(1);
            end
        end
    end

    bsg_edge_tep_checker #(
        .width_p        (width_p),
        .x_cord_width_p (x_cord_width_p),
        .y_cord_width_p (y_cord_width_p),
        .num_pkts_p     (num_pkts_p)
    ) u_checker (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .clear_i      (w_start_ok),
        .v_i          (w_link_in.v & r_ready),
        .data_i       (w_link_in.data),
        .my_x_i       (my_x_i),
        .my_y_i       (my_y_i),
        .recv_count_o (w_recv),
        .error_o      (error_o)
    );

    always_comb begin
        w_pkt_out.x_cord         = r_dest_x;
        w_pkt_out.y_cord         = r_dest_y;
        w_pkt_out.seq            = c_seq_w'(r_sent);
        w_link_out.v             = w_v;
        w_link_out.data          = w_pkt_out;
        w_link_out.ready_and_rev = r_ready;
    end

    assign link_o       = w_link_out;
    assign sent_count_o = r_sent;
    assign recv_count_o = w_recv;

endmodule

`default_nettype wire
